// File: rtl/xreg_access_ctrl.sv
// Bus-to-field-block access sequencer: accepts one request at a time, issues
// per-lane write/read strobes on an address hit and returns a one-cycle ack.
//
// state | meaning
// IDLE  | waiting for bus_req; request fields are registered on acceptance
// WR    | drive sw_wr / sw_wr_data for one cycle
// RD    | drive sw_rd for one cycle
// CAP   | capture enabled lanes of field_value into read data
// DONE  | one-cycle bus_ack with bus_err / bus_rdata
module xreg_access_ctrl #(
  parameter int                 ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  FIELD_ADDR = 8'h10
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              bus_req,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [11:0]       bus_wdata,
  input  logic [2:0]        bus_be,
  output logic              bus_ack,
  output logic              bus_err,
  output logic [11:0]       bus_rdata,
  output logic [2:0]        sw_wr,
  output logic [2:0]        sw_rd,
  output logic [11:0]       sw_wr_data,
  input  logic [11:0]       field_value,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state, state_nxt;

  logic [11:0] wdata_q;
  logic [2:0]  be_q;
  logic        err_q;
  logic [11:0] rdata_q;
  logic [11:0] cap_data;
  logic        accept;
  logic        hit;

  assign accept = (state == IDLE) && bus_req;
  assign hit    = (bus_addr == FIELD_ADDR);

  always_ff @(posedge clk) begin
    if (sync_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus_ack    = 1'b0;
    bus_err    = 1'b0;
    bus_rdata  = 12'h000;
    sw_wr      = 3'b000;
    sw_rd      = 3'b000;
    sw_wr_data = 12'h000;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus_req) begin
          if (!hit)        state_nxt = DONE;
          else if (bus_wr) state_nxt = WR;
          else             state_nxt = RD;
        end
      end
      WR: begin
        sw_wr      = be_q;
        sw_wr_data = wdata_q;
        state_nxt  = DONE;
      end
      RD: begin
        sw_rd     = be_q;
        state_nxt = CAP;
      end
      CAP: begin
        state_nxt = DONE;
      end
      DONE: begin
        bus_ack   = 1'b1;
        bus_err   = err_q;
        bus_rdata = rdata_q;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Disabled lanes read back as zero rather than stale field contents.
  always_comb begin
    cap_data = 12'h000;
    for (int i = 0; i < 3; i++) begin
      cap_data[4*i +: 4] = be_q[i] ? field_value[4*i +: 4] : 4'h0;
    end
  end

  // rdata_q is cleared on acceptance so writes and misses return zero data.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wdata_q <= 12'h000;
      be_q    <= 3'b000;
      err_q   <= 1'b0;
      rdata_q <= 12'h000;
    end else begin
      if (accept) begin
        wdata_q <= bus_wdata;
        be_q    <= bus_be;
        err_q   <= !hit;
        rdata_q <= 12'h000;
      end
      if (state == CAP) begin
        rdata_q <= cap_data;
      end
    end
  end

endmodule
